multicycle_controller: RTL and testbench

//  Multi-cycle control FSM for the single-ported MIPS-subset CPU. Sequences one shared ALU, one

---
 rtl/multicycle_controller.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control FSM for the MIPS-subset CPU
// Moore decode from state; FETCH ir_we/pc_we follow mem_ready, BRANCH pc_we follows zero.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       illegal
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_BRANCH, S_JUMP,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_TRAP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_illegal;
    logic            w_timeout;
    logic            w_rtype, w_r_alu, w_jr, w_mem, w_i_alu, w_branch, w_jump;
    logic [2:0]      w_r_alu_op;

    assign w_rtype  = (op == OP_RTYPE);
    assign w_r_alu  = w_rtype && (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
    assign w_jr     = w_rtype && (funct == FN_JR);
    assign w_mem    = (op == OP_LW) || (op == OP_SW);
    assign w_i_alu  = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_XORI);
    assign w_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign w_jump   = (op == OP_J) || (op == OP_JAL) || w_jr;
    assign w_timeout = (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        w_r_alu_op = 3'd0;
        case (funct)
            FN_SUB:  w_r_alu_op = 3'd1;
            FN_SLT:  w_r_alu_op = 3'd3;
            default: w_r_alu_op = 3'd0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                if (w_mem)          w_next = S_MEM_ADDR;
                else if (w_i_alu)   w_next = S_EXEC_I;
                else if (w_r_alu)   w_next = S_EXEC_R;
                else if (w_branch)  w_next = S_BRANCH;
                else if (w_jump)    w_next = S_JUMP;
                else                w_next = S_TRAP;
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)      w_next = S_WB_MEM;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    // Wait counter restarts on every state change, so each memory state gets a fresh budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (mem_req && !mem_ready)
                r_wait_cnt <= r_wait_cnt + CW'(1);
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;

    // Gating on reset keeps every enable low for the whole reset window, even mid-access.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 3'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: alu_src_b = 2'd3;
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = w_r_alu_op;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = (op == OP_XORI) ? 3'd2 : 3'd0;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = w_rtype ? 2'd1 : 2'd0;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'd1;
                    pc_src    = 2'd1;
                    pc_we     = (op == OP_BNE) ? !zero : zero;
                end
                S_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = w_jr ? 2'd3 : 2'd2;
                    if (op == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd3;
                        mem_to_reg = 2'd2;
                    end
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t  w;
        string tag;
    } exp_t;

    localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_ADDI = 3, K_ADDIU = 4, K_XORI = 5;
    localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9, K_J = 10, K_JAL = 11, K_JR = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, reg_write, illegal;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic [2:0] alu_op;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    multicycle_controller #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected control words, one per cycle, built from the instruction-level rules.
    function automatic ctl_t c_none();
        ctl_t c = '0;
        return c;
    endfunction

    function automatic ctl_t c_fetch(logic rdy);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.alu_src_b = 2'd1; c.ir_we = rdy; c.pc_we = rdy;
        return c;
    endfunction

    function automatic ctl_t c_alu(logic a, logic [1:0] b, logic [2:0] aop);
        ctl_t c = '0;
        c.alu_src_a = a; c.alu_src_b = b; c.alu_op = aop;
        return c;
    endfunction

    function automatic ctl_t c_wb(logic [1:0] dst, logic [1:0] m2r);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = dst; c.mem_to_reg = m2r;
        return c;
    endfunction

    function automatic ctl_t c_mem(logic we);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = we;
        return c;
    endfunction

    function automatic ctl_t c_branch(logic taken);
        ctl_t c = c_alu(1'b1, 2'd0, 3'd1);
        c.pc_src = 2'd1; c.pc_we = taken;
        return c;
    endfunction

    function automatic ctl_t c_jump(logic [1:0] src, logic link);
        ctl_t c = '0;
        c.pc_we = 1'b1; c.pc_src = src;
        if (link) begin
            c.reg_write = 1'b1; c.reg_dst = 2'd3; c.mem_to_reg = 2'd2;
        end
        return c;
    endfunction

    function automatic ctl_t c_trap();
        ctl_t c = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

    task automatic drive(input logic rst, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic rdy, input ctl_t e, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        reset = rst; op = o; funct = f; zero = z; mem_ready = rdy;
        x.w = e; x.tag = tag;
        q.push_back(x);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 6'h23, 6'($urandom), 1'($urandom), 1'b1, c_none(), "reset");
    endtask

    task automatic run_instr(input int k, input logic z, input int wf, input int wm);
        logic [5:0] o;
        logic [5:0] f;
        logic [2:0] aop;
        f = 6'($urandom);
        aop = 3'd0;
        case (k)
            K_ADD:   begin o = 6'h00; f = 6'h20; end
            K_SUB:   begin o = 6'h00; f = 6'h22; aop = 3'd1; end
            K_SLT:   begin o = 6'h00; f = 6'h2A; aop = 3'd3; end
            K_ADDI:  o = 6'h08;
            K_ADDIU: o = 6'h09;
            K_XORI:  begin o = 6'h0E; aop = 3'd2; end
            K_LW:    o = 6'h23;
            K_SW:    o = 6'h2B;
            K_BEQ:   o = 6'h04;
            K_BNE:   o = 6'h05;
            K_J:     o = 6'h02;
            K_JAL:   o = 6'h03;
            default: begin o = 6'h00; f = 6'h08; end
        endcase
        for (int i = 0; i < wf; i++) drive(1'b0, o, f, z, 1'b0, c_fetch(1'b0), "fetch_wait");
        drive(1'b0, o, f, z, 1'b1, c_fetch(1'b1), "fetch");
        drive(1'b0, o, f, z, 1'($urandom), c_alu(1'b0, 2'd3, 3'd0), "decode");
        case (k)
            K_ADD, K_SUB, K_SLT: begin
                drive(1'b0, o, f, z, 1'($urandom), c_alu(1'b1, 2'd0, aop), "exec_r");
                drive(1'b0, o, f, z, 1'($urandom), c_wb(2'd1, 2'd0), "wb_r");
            end
            K_ADDI, K_ADDIU, K_XORI: begin
                drive(1'b0, o, f, z, 1'($urandom), c_alu(1'b1, 2'd2, aop), "exec_i");
                drive(1'b0, o, f, z, 1'($urandom), c_wb(2'd0, 2'd0), "wb_i");
            end
            K_LW, K_SW: begin
                drive(1'b0, o, f, z, 1'($urandom), c_alu(1'b1, 2'd2, 3'd0), "mem_addr");
                for (int i = 0; i < wm; i++)
                    drive(1'b0, o, f, z, 1'b0, c_mem(k == K_SW), "mem_wait");
                drive(1'b0, o, f, z, 1'b1, c_mem(k == K_SW), "mem_done");
                if (k == K_LW)
                    drive(1'b0, o, f, z, 1'($urandom), c_wb(2'd0, 2'd1), "wb_mem");
            end
            K_BEQ:   drive(1'b0, o, f, z, 1'($urandom), c_branch(z), "beq");
            K_BNE:   drive(1'b0, o, f, z, 1'($urandom), c_branch(!z), "bne");
            K_J:     drive(1'b0, o, f, z, 1'($urandom), c_jump(2'd2, 1'b0), "j");
            K_JAL:   drive(1'b0, o, f, z, 1'($urandom), c_jump(2'd2, 1'b1), "jal");
            default: drive(1'b0, o, f, z, 1'($urandom), c_jump(2'd3, 1'b0), "jr");
        endcase
    endtask

    task automatic run_illegal(input logic [5:0] o, input logic [5:0] f);
        drive(1'b0, o, f, 1'b0, 1'b1, c_fetch(1'b1), "fetch");
        drive(1'b0, o, f, 1'b0, 1'b1, c_alu(1'b0, 2'd3, 3'd0), "decode");
        for (int i = 0; i < 4; i++)
            drive(1'b0, 6'h23, 6'($urandom), 1'($urandom), 1'($urandom), c_trap(), "trap_sticky");
    endtask

    // Monitor: every cycle with a pending expectation is compared at the falling edge.
    initial begin
        exp_t  x;
        ctl_t  act;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                x = q.pop_front();
                act = '{mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                        alu_op, reg_write, reg_dst, mem_to_reg, illegal};
                checks++;
                if (act !== x.w) begin
                    errors++;
                    $display("FAIL %s cycle=%0d got=%05h exp=%05h", x.tag, cyc, act, x.w);
                end
            end
        end
    end

    initial begin
        int k, wf, wm;
        do_reset(3);
        // ADD, zero-wait: write-back on cycle 4, next fetch on cycle 5.
        run_instr(K_ADD, 1'b0, 0, 0);
        run_instr(K_LW, 1'b1, 3, 3);
        run_instr(K_BEQ, 1'b1, 0, 0);
        run_instr(K_BEQ, 1'b0, 0, 0);
        run_instr(K_BNE, 1'b1, 0, 0);
        run_instr(K_BNE, 1'b0, 0, 0);
        run_instr(K_JAL, 1'b0, 0, 0);
        run_instr(K_JR, 1'b0, 0, 0);
        run_instr(K_SW, 1'b0, 0, 0);
        run_instr(K_LW, 1'b0, 0, 15);
        run_instr(K_SW, 1'b0, 15, 0);
        for (int n = 0; n < 200; n++) begin
            k  = $urandom_range(0, 12);
            wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            wm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_instr(k, 1'($urandom), wf, wm);
        end
        // Reset while SW is stalled in its write cycle.
        drive(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, c_fetch(1'b1), "fetch");
        drive(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, c_alu(1'b0, 2'd3, 3'd0), "decode");
        drive(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, c_alu(1'b1, 2'd2, 3'd0), "mem_addr");
        drive(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, c_mem(1'b1), "mem_wr_stall");
        drive(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, c_mem(1'b1), "mem_wr_stall");
        do_reset(2);
        run_instr(K_XORI, 1'b0, 1, 0);
        // Undecodable opcode and undecodable funct both trap with sticky illegal.
        run_illegal(6'h3F, 6'h00);
        do_reset(2);
        run_instr(K_SUB, 1'b0, 0, 0);
        run_illegal(6'h00, 6'h21);
        do_reset(2);
        // Memory that never answers: 16 stalled read cycles, then trap.
        drive(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, c_fetch(1'b1), "fetch");
        drive(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, c_alu(1'b0, 2'd3, 3'd0), "decode");
        drive(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, c_alu(1'b1, 2'd2, 3'd0), "mem_addr");
        for (int i = 0; i < 16; i++)
            drive(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, c_mem(1'b0), "mem_rd_stall");
        for (int i = 0; i < 3; i++)
            drive(1'b0, 6'h23, 6'h00, 1'b0, 1'($urandom), c_trap(), "timeout_trap");
        do_reset(2);
        run_instr(K_J, 1'b0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
